// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// The in-order pipeline writeback has priority; long-latency results wait in a
// small FIFO and drain into free pipeline slots. An age counter on the FIFO
// head stalls the pipeline for one cycle once the head has waited MAX_WAIT
// cycles, so long-latency results always make forward progress.
module wb_port_arbiter #(
  parameter int XLEN        = 32,
  parameter int RF_IDX_BITS = 5,
  parameter int DEPTH       = 4,
  parameter int MAX_WAIT    = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         wb_valid_i,
  input  logic                         wb_rd_we_i,
  input  logic [RF_IDX_BITS-1:0]       wb_rd_s_i,
  input  logic [XLEN-1:0]              wb_rd_v_i,
  output logic                         wb_stall_o,
  input  logic                         ll_valid_i,
  output logic                         ll_ready_o,
  input  logic [RF_IDX_BITS-1:0]       ll_rd_s_i,
  input  logic [XLEN-1:0]              ll_rd_v_i,
  output logic                         rf_we_o,
  output logic [RF_IDX_BITS-1:0]       rf_rd_s_o,
  output logic [XLEN-1:0]              rf_rd_v_o,
  output logic [$clog2(DEPTH+1)-1:0]   ll_pending_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int AW = $clog2(MAX_WAIT + 1);

  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [AW-1:0] AGE_MAX  = AW'(MAX_WAIT);
  localparam logic [AW-1:0] AGE_ONE  = AW'(1);

  // FIFO storage; contents are qualified by count_q so no reset is needed
  logic [RF_IDX_BITS-1:0] fifoIdx_q  [DEPTH];
  logic [XLEN-1:0]        fifoData_q [DEPTH];

  logic [PW-1:0]          rdPtr_q, rdPtr_d;
  logic [PW-1:0]          wrPtr_q, wrPtr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [AW-1:0]          age_q, age_d;

  logic                   rfWe_q, rfWe_d;
  logic [RF_IDX_BITS-1:0] rfIdx_q, rfIdx_d;
  logic [XLEN-1:0]        rfData_q, rfData_d;

  logic plReq;
  logic llReady;
  logic llFire;
  logic enq;
  logic deq;
  logic fifoNonEmpty;
  logic starve;
  logic grantLl;
  logic grantPl;

  assign plReq        = wb_valid_i && wb_rd_we_i && (wb_rd_s_i != '0);
  assign fifoNonEmpty = (count_q != '0);
  assign llReady      = (count_q < CNT_FULL);
  assign llFire       = ll_valid_i && llReady;
  assign enq          = llFire && (ll_rd_s_i != '0);
  assign starve       = (age_q == AGE_MAX);
  assign grantLl      = fifoNonEmpty && (!plReq || starve);
  assign grantPl      = plReq && !grantLl;
  assign deq          = grantLl;

  assign ll_ready_o   = llReady;
  assign wb_stall_o   = plReq && starve && fifoNonEmpty;
  assign rf_we_o      = rfWe_q;
  assign rf_rd_s_o    = rfIdx_q;
  assign rf_rd_v_o    = rfData_q;
  assign ll_pending_o = count_q;

  // Next-state for FIFO pointers, occupancy, head age and the write port
  always_comb begin
    rdPtr_d  = rdPtr_q;
    wrPtr_d  = wrPtr_q;
    count_d  = count_q;
    age_d    = age_q;
    rfWe_d   = 1'b0;
    rfIdx_d  = rfIdx_q;
    rfData_d = rfData_q;

    if (enq) begin
      wrPtr_d = wrPtr_q + PTR_ONE;
    end
    if (deq) begin
      rdPtr_d = rdPtr_q + PTR_ONE;
    end
    if (enq && !deq) begin
      count_d = count_q + CNT_ONE;
    end else if (deq && !enq) begin
      count_d = count_q - CNT_ONE;
    end

    if (!fifoNonEmpty || deq) begin
      age_d = '0;
    end else if (!starve) begin
      age_d = age_q + AGE_ONE;
    end

    if (grantLl) begin
      rfWe_d   = 1'b1;
      rfIdx_d  = fifoIdx_q[rdPtr_q];
      rfData_d = fifoData_q[rdPtr_q];
    end else if (grantPl) begin
      rfWe_d   = 1'b1;
      rfIdx_d  = wb_rd_s_i;
      rfData_d = wb_rd_v_i;
    end
  end

  // Control state and registered register-file write port
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rdPtr_q  <= '0;
      wrPtr_q  <= '0;
      count_q  <= '0;
      age_q    <= '0;
      rfWe_q   <= 1'b0;
      rfIdx_q  <= '0;
      rfData_q <= '0;
    end else begin
      rdPtr_q  <= rdPtr_d;
      wrPtr_q  <= wrPtr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      rfWe_q   <= rfWe_d;
      rfIdx_q  <= rfIdx_d;
      rfData_q <= rfData_d;
    end
  end

  // Capture accepted long-latency results at the tail of the FIFO
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifoIdx_q[wrPtr_q]  <= ll_rd_s_i;
      fifoData_q[wrPtr_q] <= ll_rd_v_i;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed vector table, hand-written
// multi-cycle sequences and a randomized run against a queue-based model.
module tb_wb_port_arbiter;

  localparam int XLEN        = 32;
  localparam int RF_IDX_BITS = 5;
  localparam int DEPTH       = 4;
  localparam int MAX_WAIT    = 8;
  localparam int CW          = $clog2(DEPTH + 1);

  logic                   clock = 1'b0;
  logic                   rstN;
  logic                   wbValid;
  logic                   wbWe;
  logic [RF_IDX_BITS-1:0] wbIdx;
  logic [XLEN-1:0]        wbData;
  logic                   wbStall;
  logic                   llValid;
  logic                   llReady;
  logic [RF_IDX_BITS-1:0] llIdx;
  logic [XLEN-1:0]        llData;
  logic                   rfWe;
  logic [RF_IDX_BITS-1:0] rfIdx;
  logic [XLEN-1:0]        rfData;
  logic [CW-1:0]          llPending;

  int testsRun    = 0;
  int testsFailed = 0;

  // Free-running clock, period 10
  always #5 clock = ~clock;

  wb_port_arbiter #(
    .XLEN(XLEN), .RF_IDX_BITS(RF_IDX_BITS), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i(clock), .rst_i(rstN),
    .wb_valid_i(wbValid), .wb_rd_we_i(wbWe), .wb_rd_s_i(wbIdx), .wb_rd_v_i(wbData),
    .wb_stall_o(wbStall),
    .ll_valid_i(llValid), .ll_ready_o(llReady), .ll_rd_s_i(llIdx), .ll_rd_v_i(llData),
    .rf_we_o(rfWe), .rf_rd_s_o(rfIdx), .rf_rd_v_o(rfData),
    .ll_pending_o(llPending)
  );

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
  } entry_t;

  // Reference model: pending results as a queue, head wait time, last write
  entry_t      llQ[$];
  int          ageM;
  logic        expWe;
  logic [4:0]  expIdx;
  logic [31:0] expData;

  typedef struct {
    logic        wbV;
    logic        wbW;
    logic [4:0]  wbS;
    logic [31:0] wbD;
    logic        llV;
    logic [4:0]  llS;
    logic [31:0] llD;
    logic        eWe;
    logic [4:0]  eIdx;
    logic [31:0] eData;
    int          ePend;
    logic        eReady;
    logic        eStall;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic wbV, input logic wbW, input logic [4:0] wbS,
                               input logic [31:0] wbD, input logic llV,
                               input logic [4:0] llS, input logic [31:0] llD);
    wbValid = wbV;
    wbWe    = wbW;
    wbIdx   = wbS;
    wbData  = wbD;
    llValid = llV;
    llIdx   = llS;
    llData  = llD;
    #1;
  endtask

  task automatic resetModel();
    llQ.delete();
    ageM    = 0;
    expWe   = 1'b0;
    expIdx  = '0;
    expData = '0;
  endtask

  task automatic checkModel(input string tag);
    bit plReq;
    plReq = wbValid && wbWe && (wbIdx != 0);
    checkOutput({tag, ".we"},      32'(rfWe),      32'(expWe));
    checkOutput({tag, ".idx"},     32'(rfIdx),     32'(expIdx));
    checkOutput({tag, ".data"},    rfData,         expData);
    checkOutput({tag, ".pending"}, 32'(llPending), 32'(llQ.size()));
    checkOutput({tag, ".ready"},   32'(llReady),   32'(llQ.size() < DEPTH));
    checkOutput({tag, ".stall"},   32'(wbStall),
                32'(plReq && (ageM == MAX_WAIT) && (llQ.size() > 0)));
  endtask

  // Optionally compare against the model, then advance model and DUT one edge
  task automatic finishCycle(input bit compareModel, input string tag);
    bit     plReq;
    bit     headGo;
    bit     llAcc;
    int     sz;
    int     nextAge;
    entry_t head;
    entry_t incoming;
    if (compareModel) checkModel(tag);
    sz       = llQ.size();
    plReq    = wbValid && wbWe && (wbIdx != 0);
    headGo   = (sz > 0) && (!plReq || (ageM == MAX_WAIT));
    llAcc    = llValid && (sz < DEPTH) && (llIdx != 0);
    incoming = '{idx: llIdx, data: llData};
    if (sz == 0 || headGo) nextAge = 0;
    else nextAge = (ageM + 1 > MAX_WAIT) ? MAX_WAIT : ageM + 1;
    head = '{idx: 5'd0, data: 32'd0};
    if (headGo) head = llQ[0];
    @(posedge clock);
    if (headGo) begin
      void'(llQ.pop_front());
      expWe   = 1'b1;
      expIdx  = head.idx;
      expData = head.data;
    end else if (plReq) begin
      expWe   = 1'b1;
      expIdx  = wbIdx;
      expData = wbData;
    end else begin
      expWe   = 1'b0;
    end
    if (llAcc) llQ.push_back(incoming);
    ageM = nextAge;
    @(negedge clock);
  endtask

  // Watchdog so the run always terminates
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int     k;
    int     n;
    bit     stallSeen;
    bit     acc;
    bit     llHeld;
    bit     wbHeld;
    string  tag;

    vecs[0] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,        0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 0, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 32'hDEADBEEF, 0, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 32'h1234, 1'b0, 5'd5, 32'hDEADBEEF, 0, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 32'hDEADBEEF, 1, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234,     0, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'h55, 1'b0, 5'd7, 32'h1234,    0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 32'h1234,     0, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 5'd3, 32'h77,       1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 32'h1234,     0, 1'b1, 1'b0};
    vecs[9] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 32'h1234,     0, 1'b1, 1'b0};

    // Power-on reset
    rstN = 1'b0;
    resetModel();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(negedge clock);
    @(negedge clock);
    #1;
    checkModel("reset");
    @(negedge clock);
    rstN = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].wbV, vecs[i].wbW, vecs[i].wbS, vecs[i].wbD,
                    vecs[i].llV, vecs[i].llS, vecs[i].llD);
      tag = $sformatf("vec%0d", i);
      checkOutput({tag, ".we"},      32'(rfWe),      32'(vecs[i].eWe));
      checkOutput({tag, ".idx"},     32'(rfIdx),     32'(vecs[i].eIdx));
      checkOutput({tag, ".data"},    rfData,         vecs[i].eData);
      checkOutput({tag, ".pending"}, 32'(llPending), 32'(vecs[i].ePend));
      checkOutput({tag, ".ready"},   32'(llReady),   32'(vecs[i].eReady));
      checkOutput({tag, ".stall"},   32'(wbStall),   32'(vecs[i].eStall));
      finishCycle(1'b0, tag);
    end

    // Starvation: pipeline writes every cycle, one long-latency result waits
    k = 0;
    for (int c = 0; c < 13; c++) begin
      applyStimulus(1'b1, 1'b1, 5'(k + 1), 32'h100 + 32'(k), c == 0, 5'd9, 32'hA5);
      tag = $sformatf("starve%0d", c);
      if (c >= 1 && c <= 9) checkOutput({tag, ".stallAt9"}, 32'(wbStall), 32'(c == 9));
      if (c == 10) begin
        checkOutput({tag, ".llWe"},   32'(rfWe),  32'd1);
        checkOutput({tag, ".llIdx"},  32'(rfIdx), 32'd9);
        checkOutput({tag, ".llData"}, rfData,     32'hA5);
      end
      if (c == 11) begin
        checkOutput({tag, ".heldIdx"},  32'(rfIdx), 32'd10);
        checkOutput({tag, ".heldData"}, rfData,     32'h109);
      end
      stallSeen = wbStall;
      finishCycle(1'b1, tag);
      if (!stallSeen) k++;
    end

    // Full FIFO and in-order drain
    n = 1;
    for (int c = 0; c < 12; c++) begin
      applyStimulus(c < 5, 1'b1, 5'd20, 32'h2000 + 32'(c),
                    n <= 5, 5'(n), 32'h1000 + 32'(n));
      tag = $sformatf("full%0d", c);
      if (c == 4) begin
        checkOutput({tag, ".readyLow"}, 32'(llReady),   32'd0);
        checkOutput({tag, ".pend4"},    32'(llPending), 32'd4);
      end
      if (c >= 6 && c <= 10) begin
        checkOutput({tag, ".drainWe"},   32'(rfWe),  32'd1);
        checkOutput({tag, ".drainIdx"},  32'(rfIdx), 32'(c - 5));
        checkOutput({tag, ".drainData"}, rfData,     32'h1000 + 32'(c - 5));
      end
      acc = llValid && llReady;
      finishCycle(1'b1, tag);
      if (acc) n++;
    end

    // Reset mid-stream with three entries pending
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b1, 1'b1, 5'd3, 32'h3000 + 32'(c), 1'b1, 5'(11 + c), 32'h4000 + 32'(c));
      finishCycle(1'b1, $sformatf("prerst%0d", c));
    end
    applyStimulus(1'b1, 1'b1, 5'd3, 32'h3003, 1'b0, 5'd0, 32'h0);
    checkOutput("prerst.pend3", 32'(llPending), 32'd3);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("midrst.we",      32'(rfWe),      32'd0);
    checkOutput("midrst.pending", 32'(llPending), 32'd0);
    checkOutput("midrst.ready",   32'(llReady),   32'd1);
    checkOutput("midrst.stall",   32'(wbStall),   32'd0);
    resetModel();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    rstN = 1'b1;
    for (int c = 0; c < 6; c++) begin
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      tag = $sformatf("postrst%0d", c);
      checkOutput({tag, ".noWrite"}, 32'(rfWe), 32'd0);
      finishCycle(1'b1, tag);
    end

    // Randomized traffic against the reference model
    llHeld = 1'b0;
    wbHeld = 1'b0;
    for (int c = 0; c < 500; c++) begin
      logic        nWbV, nWbW, nLlV;
      logic [4:0]  nWbS, nLlS;
      logic [31:0] nWbD, nLlD;
      nWbV = wbValid; nWbW = wbWe; nWbS = wbIdx; nWbD = wbData;
      nLlV = llValid; nLlS = llIdx; nLlD = llData;
      if (!wbHeld) begin
        nWbV = ($urandom_range(0, 9) < 7);
        nWbW = ($urandom_range(0, 9) < 8);
        nWbS = 5'($urandom_range(0, 31));
        nWbD = $urandom;
      end
      if (!llHeld) begin
        nLlV = ($urandom_range(0, 9) < 4);
        nLlS = 5'($urandom_range(0, 31));
        nLlD = $urandom;
      end
      applyStimulus(nWbV, nWbW, nWbS, nWbD, nLlV, nLlS, nLlD);
      wbHeld = wbStall;
      llHeld = llValid && !llReady;
      finishCycle(1'b1, $sformatf("rand%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
